// File: rtl/tn_uart_tx.sv
// tn_uart_tx: serv dbus UART transmitter, 8N1, with a circular TX FIFO.
// Defining TN_UART_DIVREG_EN adds a writable divisor register at offset 0x8.
module tn_uart_tx #(
    parameter int DIV   = 234,
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    output logic        o_tx,
    output logic        o_irq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic [15:0]   cnt, div_reg, div_cur;
    logic [7:0]    sh;
    logic [2:0]    bitn;
    logic          ovf, acc, full, empty, busy, push, pop, wr_ok, unused;
    logic [1:0]    reg_sel;
    logic [31:0]   rd, div_rd;

    assign reg_sel = i_dbus_adr[3:2];
    assign acc     = i_dbus_cyc && !o_dbus_ack;
    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign busy    = state != IDLE;
    assign push    = acc && i_dbus_we && reg_sel == 2'd0 && i_dbus_sel[0];
    assign pop     = !empty && (state == IDLE || (state == STOP && cnt == '0));
    assign wr_ok   = push && (!full || pop);
    assign o_irq   = empty && !busy;
    assign rd      = reg_sel == 2'd1 ? {24'b0, 4'(count), ovf, busy, empty, full} :
                     reg_sel == 2'd2 ? div_rd : '0;
    assign unused  = &{1'b0, i_dbus_adr[31:4], i_dbus_adr[1:0], i_dbus_dat[31:8], i_dbus_sel[3:1]};

`ifdef TN_UART_DIVREG_EN
    logic [15:0] div_wr;
    assign div_wr = {i_dbus_sel[1] ? i_dbus_dat[15:8] : div_reg[15:8],
                     i_dbus_sel[0] ? i_dbus_dat[7:0]  : div_reg[7:0]};
    assign div_rd = {16'b0, div_reg};
    // The programmed divisor takes effect only at the next frame start.
    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            div_reg <= 16'(DIV);
            div_cur <= 16'(DIV);
        end else begin
            if (acc && i_dbus_we && reg_sel == 2'd2) div_reg <= div_wr < 16'd2 ? 16'd2 : div_wr;
            if (pop) div_cur <= div_reg;
        end
`else
    assign div_reg = 16'(DIV);
    assign div_cur = 16'(DIV);
    assign div_rd  = '0;
`endif

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            o_dbus_ack <= 1'b0;
            o_dbus_rdt <= '0;
            ovf        <= 1'b0;
        end else begin
            o_dbus_ack <= acc;
            if (acc) o_dbus_rdt <= i_dbus_we ? '0 : rd;
            if (push && full && !pop) ovf <= 1'b1;
            else if (acc && !i_dbus_we && reg_sel == 2'd1) ovf <= 1'b0;
        end

    always_ff @(posedge clk)
        if (wr_ok) mem[wptr] <= i_dbus_dat[7:0];

    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(wr_ok);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(wr_ok) - (AW+1)'(pop);
        end

    // A pop always enters START, whether from IDLE or straight out of STOP.
    always_ff @(posedge clk or posedge i_rst)
        if (i_rst) begin
            state <= IDLE;
            o_tx  <= 1'b1;
            cnt   <= '0;
            sh    <= '0;
            bitn  <= '0;
        end else if (pop) begin
            state <= START;
            o_tx  <= 1'b0;
            sh    <= mem[rptr];
            cnt   <= div_reg - 16'd1;
        end else if (busy) begin
            if (cnt != '0) begin
                cnt <= cnt - 16'd1;
            end else begin
                cnt <= div_cur - 16'd1;
                if (state == START) begin
                    state <= DATA;
                    o_tx  <= sh[0];
                    sh    <= sh >> 1;
                    bitn  <= '0;
                end else if (state == DATA && bitn != 3'd7) begin
                    o_tx  <= sh[0];
                    sh    <= sh >> 1;
                    bitn  <= bitn + 3'd1;
                end else if (state == DATA) begin
                    state <= STOP;
                    o_tx  <= 1'b1;
                end else begin
                    state <= IDLE;
                    o_tx  <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_tn_uart_tx.sv
// tb_tn_uart_tx: directed and random checks of tn_uart_tx against a queue-based model.
// The line monitor expects every frame as start/8 data LSB-first/stop, each bit bw cycles.
module tb_tn_uart_tx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] adr = '0, dat = '0;
    logic [3:0]  sel = '0;
    logic        we = 1'b0, cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack, o_tx, o_irq;

    tn_uart_tx #(.DIV(4), .DEPTH(8)) dut (
        .clk(clk), .i_rst(rst), .i_dbus_adr(adr), .i_dbus_dat(dat), .i_dbus_sel(sel),
        .i_dbus_we(we), .i_dbus_cyc(cyc), .o_dbus_rdt(o_dbus_rdt), .o_dbus_ack(o_dbus_ack),
        .o_tx(o_tx), .o_irq(o_irq)
    );

    always #5 clk = ~clk;

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int         tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    int         bw = 4, pos = 0, frames_started = 0, frames_done = 0, last_ack = 0;
    bit         in_frame = 0, ovf_m = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line monitor: pops the model FIFO at each start bit and checks every cycle of the frame.
    initial begin
        logic [9:0] frame;
        logic [7:0] b;
        bit ok, aborted;
        forever begin
            @(posedge clk); #1;
            if (rst) in_frame = 0;
            else if (o_tx === 1'b0) begin
                in_frame = 1;
                frames_started++;
                start_q.push_back(cyc_n);
                ok = exp_q.size() != 0;
                b = ok ? exp_q.pop_front() : 8'hxx;
                frame = {1'b1, b, 1'b0};
                aborted = 0;
                for (int k = 0; k < 10*bw && !aborted; k++) begin
                    if (k > 0) begin @(posedge clk); #1; end
                    pos = k;
                    if (rst) aborted = 1;
                    else if (o_tx !== frame[k/bw]) ok = 0;
                end
                if (aborted) in_frame = 0;
                else begin
                    frames_done++;
                    chk("frame", {31'b0, ok}, 32'h1);
                end
            end else in_frame = 0;
        end
    end

    task automatic bus(input logic w, input logic [3:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] r);
        int n;
        logic pp;
        logic [31:0] st;
        @(negedge clk);
        n  = exp_q.size();
        pp = n > 0 && (!in_frame || pos == 10*bw - 1);
        st = {24'b0, 4'(n), ovf_m, in_frame, n == 0, n == 8};
        cyc = 1; we = w; adr = {28'b0, off}; dat = d; sel = s;
        @(posedge clk); #2;
        chk("ack", {31'b0, o_dbus_ack}, 32'h1);
        r = o_dbus_rdt;
        last_ack = cyc_n;
        cyc = 0; we = 0;
        if (w && off == 4'h0 && s[0]) begin
            if (n == 8 && !pp) ovf_m = 1;
            else exp_q.push_back(d[7:0]);
        end
        if (!w && off == 4'h4) begin
            chk("status", r, st);
            ovf_m = 0;
        end else if (!w && off != 4'h8) chk("rdt_zero", r, 32'h0);
        @(posedge clk); #2;
        chk("ack_pulse", {31'b0, o_dbus_ack}, 32'h0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || in_frame) && t < 20000) begin
            @(posedge clk); #2;
            t++;
        end
        chk("drain", {31'b0, t < 20000}, 32'h1);
    endtask

    task automatic wait_started(input int n);
        int t = 0;
        while (frames_started < n && t < 2000) begin
            @(posedge clk); #2;
            t++;
        end
        chk("wait_start", {31'b0, frames_started >= n}, 32'h1);
    endtask

    initial begin
        logic [31:0] r;
        int base, lows, t;
        #12;
        chk("rst_tx", {31'b0, o_tx}, 32'h1);
        chk("rst_ack", {31'b0, o_dbus_ack}, 32'h0);
        chk("rst_rdt", o_dbus_rdt, 32'h0);
        chk("rst_irq", {31'b0, o_irq}, 32'h1);
        @(negedge clk) rst = 0;
        bus(0, 4'h4, 0, 4'hf, r);
        chk("status_reset", r, 32'h2);

        // single 0x55 frame, one access, one push
        bus(1, 4'h0, 32'h55, 4'h1, r);
        wait_started(1);
        chk("latency_le3", {31'b0, start_q[0] - last_ack <= 3}, 32'h1);
        chk("irq_busy", {31'b0, o_irq}, 32'h0);
        wait_idle();
        repeat (8) @(posedge clk);
        #2;
        chk("one_frame", frames_done, 1);
        chk("irq_idle", {31'b0, o_irq}, 32'h1);

        // back-to-back frames, no gap
        start_q.delete();
        bus(1, 4'h0, 32'h41, 4'h1, r);
        bus(1, 4'h0, 32'h42, 4'h1, r);
        wait_started(3);
        repeat (10) @(posedge clk);
        bus(0, 4'h4, 0, 4'hf, r);
        chk("status_mid_f2", r, 32'h6);
        chk("no_gap", start_q[1] - start_q[0], 40);
        wait_idle();

        // overflow: 10 writes while the line is busy
        for (int i = 0; i < 10; i++) bus(1, 4'h0, 32'(8'h10 + i), 4'h1, r);
        bus(0, 4'h4, 0, 4'hf, r);
        chk("ovf_set", r, 32'h8d);
        bus(0, 4'h4, 0, 4'hf, r);
        chk("ovf_clear", r & 32'h8, 32'h0);
        wait_idle();
        chk("ovf_frames", frames_done, 12);

        // random mix against the model
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: bus(1, 4'h0, $urandom, 4'($urandom_range(0, 15)), r);
                5, 6:          bus(0, 4'h4, 0, 4'hf, r);
                7:             bus(0, 4'h0, 0, 4'hf, r);
                8:             bus(0, 4'hc, 0, 4'hf, r);
                default:       bus(1, 4'hc, $urandom, 4'hf, r);
            endcase
            repeat ($urandom_range(0, 25)) @(posedge clk);
        end
        wait_idle();
        bus(0, 4'h4, 0, 4'hf, r);

        // reset in data bit 3 of 0xA5 (that bit is 0)
        base = frames_done;
        bus(1, 4'h0, 32'ha5, 4'h1, r);
        t = 0;
        while (!(in_frame && pos == 17) && t < 500) begin
            @(posedge clk); #2;
            t++;
        end
        chk("reach_bit3", {31'b0, t < 500}, 32'h1);
        @(negedge clk);
        chk("tx_bit3", {31'b0, o_tx}, 32'h0);
        rst = 1;
        #1;
        chk("rst_async_tx", {31'b0, o_tx}, 32'h1);
        chk("rst_async_irq", {31'b0, o_irq}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 0;
        exp_q.delete();
        ovf_m = 0;
        lows = 0;
        repeat (60) begin
            @(posedge clk); #2;
            if (o_tx !== 1'b1) lows++;
        end
        chk("no_tx_after_rst", lows, 0);
        chk("aborted_frame", frames_done, base);
        bus(0, 4'h4, 0, 4'hf, r);
        chk("status_after_rst", r, 32'h2);

        // divisor register
        bus(1, 4'h8, 32'h1, 4'h3, r);
        bus(0, 4'h8, 0, 4'hf, r);
`ifdef TN_UART_DIVREG_EN
        chk("div_read", r, 32'h2);
        bw = 2;
`else
        chk("div_read", r, 32'h0);
`endif
        base = frames_done;
        bus(1, 4'h0, 32'h3c, 4'h1, r);
        wait_idle();
        chk("div_frame", frames_done - base, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end
endmodule
